// File: rtl/pio_regs_pkg.sv
// Shared register map, reset values and field layout for the PIO control/status register file.
package pio_regs_pkg;

  localparam logic [31:0] AddrCtrl    = 32'h000;
  localparam logic [31:0] AddrFstat   = 32'h004;
  localparam logic [31:0] AddrFdebug  = 32'h008;
  localparam logic [31:0] AddrFlevel  = 32'h00C;
  localparam logic [31:0] AddrIrq     = 32'h030;
  localparam logic [31:0] AddrSmBase  = 32'h0C8;
  localparam logic [31:0] SmStride    = 32'h018;
  localparam logic [31:0] AddrIntr    = 32'h128;
  localparam logic [31:0] AddrIrqBase = 32'h12C;
  localparam logic [31:0] IrqStride   = 32'h00C;

  localparam logic [31:0] OffClkdiv    = 32'h00;
  localparam logic [31:0] OffExecctrl  = 32'h04;
  localparam logic [31:0] OffShiftctrl = 32'h08;
  localparam logic [31:0] OffAddr      = 32'h0C;
  localparam logic [31:0] OffInstr     = 32'h10;
  localparam logic [31:0] OffPinctrl   = 32'h14;

  localparam logic [31:0] OffInte = 32'h0;
  localparam logic [31:0] OffIntf = 32'h4;
  localparam logic [31:0] OffInts = 32'h8;

  localparam logic [31:0] RstClkdiv    = 32'h0001_0000;
  localparam logic [31:0] RstExecctrl  = 32'h0001_F000;
  localparam logic [31:0] RstShiftctrl = 32'h000C_0000;
  localparam logic [31:0] RstPinctrl   = 32'h1400_0000;

  localparam int unsigned FdTxStall = 24;
  localparam int unsigned FdTxOver  = 16;
  localparam int unsigned FdRxUnder = 8;
  localparam int unsigned FdRxStall = 0;

  // INTR = {IRQ[3:0], tx_nfull[3:0], rx_nempty[3:0]}
  localparam int unsigned IntrW = 12;

  function automatic logic [31:0] sm_reg_addr(int unsigned n, logic [31:0] off);
    return AddrSmBase + SmStride * n + off;
  endfunction

  function automatic logic [31:0] irq_reg_addr(int unsigned k, logic [31:0] off);
    return AddrIrqBase + IrqStride * k + off;
  endfunction

endpackage

// File: rtl/pio_ctrl_regs_if.sv
// Bus-side register access: single-cycle writes, registered reads with a valid flag.
interface pio_ctrl_regs_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/pio_irq_agg.sv
// One system interrupt line: enable/force registers over the raw INTR vector, registered output.
module pio_irq_agg
  import pio_regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IntrW-1:0] intr,
  input  logic             inte_we,
  input  logic             intf_we,
  input  logic [IntrW-1:0] wr_data,
  output logic [IntrW-1:0] inte,
  output logic [IntrW-1:0] intf,
  output logic [IntrW-1:0] ints,
  output logic             irq
);

  logic [IntrW-1:0] inte_q, intf_q;
  logic             irq_q;

  always_comb begin
    ints = (intr & inte_q) | intf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inte_q <= '0;
      intf_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (inte_we) inte_q <= wr_data;
      if (intf_we) intf_q <= wr_data;
      irq_q <= |ints;
    end
  end

  assign inte = inte_q;
  assign intf = intf_q;
  assign irq  = irq_q;

endmodule

// File: rtl/pio_ctrl_regs.sv
// PIO control/status register file: per-SM config, sticky debug flags, IRQ flags and
// IRQ_LINES masked/forceable interrupt outputs.
module pio_ctrl_regs
  import pio_regs_pkg::*;
#(
  parameter int unsigned NUM_SM    = 4,
  parameter int unsigned IRQ_LINES = 2,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pio_ctrl_regs_if.slave         bus,
  input  logic [NUM_SM-1:0]      tx_stall,
  input  logic [NUM_SM-1:0]      tx_over,
  input  logic [NUM_SM-1:0]      rx_under,
  input  logic [NUM_SM-1:0]      rx_stall,
  input  logic [7:0]             irq_set,
  input  logic [7:0]             irq_clr,
  input  logic [31:0]            fstat,
  input  logic [31:0]            flevel,
  input  logic [5*NUM_SM-1:0]    sm_pc,
  input  logic [NUM_SM-1:0]      tx_nfull,
  input  logic [NUM_SM-1:0]      rx_nempty,
  output logic [NUM_SM-1:0]      sm_enable,
  output logic [NUM_SM-1:0]      sm_restart,
  output logic [NUM_SM-1:0]      clkdiv_restart,
  output logic [32*NUM_SM-1:0]   clkdiv,
  output logic [32*NUM_SM-1:0]   execctrl,
  output logic [32*NUM_SM-1:0]   shiftctrl,
  output logic [32*NUM_SM-1:0]   pinctrl,
  output logic [16*NUM_SM-1:0]   instr_data,
  output logic [NUM_SM-1:0]      instr_wr,
  output logic [7:0]             irq_flags,
  output logic [IRQ_LINES-1:0]   irq_out
);

  logic [ADDR_W-1:0] wr_addr_raw, rd_addr_raw;
  logic [31:0]       waddr, raddr;

  assign wr_addr_raw = bus.wr_addr;
  assign rd_addr_raw = bus.rd_addr;
  assign waddr = 32'(wr_addr_raw) & 32'hFFFF_FFFC;
  assign raddr = 32'(rd_addr_raw) & 32'hFFFF_FFFC;

  logic [NUM_SM-1:0] enable_q, sm_restart_q, clkdiv_restart_q, instr_wr_q;
  logic [31:0]       fdebug_q, fdebug_d;
  logic [7:0]        irq_q, irq_d;
  logic [31:0]       clkdiv_q    [NUM_SM];
  logic [31:0]       execctrl_q  [NUM_SM];
  logic [31:0]       shiftctrl_q [NUM_SM];
  logic [31:0]       pinctrl_q   [NUM_SM];
  logic [15:0]       instr_q     [NUM_SM];
  logic [31:0]       rd_data_q, rd_mux;
  logic              rd_valid_q;

  logic                 wr_ctrl, wr_fdebug, wr_irq;
  logic [NUM_SM-1:0]    wr_clkdiv, wr_execctrl, wr_shiftctrl, wr_pinctrl, wr_instr;
  logic [IRQ_LINES-1:0] wr_inte, wr_intf;
  logic [31:0]          fd_ev, fd_mask;
  logic [IntrW-1:0]     intr;
  logic [IntrW-1:0]     inte [IRQ_LINES];
  logic [IntrW-1:0]     intf [IRQ_LINES];
  logic [IntrW-1:0]     ints [IRQ_LINES];

  // Write decode; absent SM/IRQ slots never decode so their writes fall away.
  always_comb begin
    wr_ctrl      = bus.wr_en && (waddr == AddrCtrl);
    wr_fdebug    = bus.wr_en && (waddr == AddrFdebug);
    wr_irq       = bus.wr_en && (waddr == AddrIrq);
    wr_clkdiv    = '0;
    wr_execctrl  = '0;
    wr_shiftctrl = '0;
    wr_pinctrl   = '0;
    wr_instr     = '0;
    wr_inte      = '0;
    wr_intf      = '0;
    for (int unsigned n = 0; n < NUM_SM; n++) begin
      wr_clkdiv[n]    = bus.wr_en && (waddr == sm_reg_addr(n, OffClkdiv));
      wr_execctrl[n]  = bus.wr_en && (waddr == sm_reg_addr(n, OffExecctrl));
      wr_shiftctrl[n] = bus.wr_en && (waddr == sm_reg_addr(n, OffShiftctrl));
      wr_pinctrl[n]   = bus.wr_en && (waddr == sm_reg_addr(n, OffPinctrl));
      wr_instr[n]     = bus.wr_en && (waddr == sm_reg_addr(n, OffInstr));
    end
    for (int unsigned k = 0; k < IRQ_LINES; k++) begin
      wr_inte[k] = bus.wr_en && (waddr == irq_reg_addr(k, OffInte));
      wr_intf[k] = bus.wr_en && (waddr == irq_reg_addr(k, OffIntf));
    end
  end

  // Sticky flags: a hardware event in the same cycle as its W1C keeps the bit set.
  always_comb begin
    fd_ev   = '0;
    fd_mask = '0;
    for (int unsigned n = 0; n < NUM_SM; n++) begin
      fd_ev[FdTxStall + n]   = tx_stall[n];
      fd_ev[FdTxOver + n]    = tx_over[n];
      fd_ev[FdRxUnder + n]   = rx_under[n];
      fd_ev[FdRxStall + n]   = rx_stall[n];
      fd_mask[FdTxStall + n] = 1'b1;
      fd_mask[FdTxOver + n]  = 1'b1;
      fd_mask[FdRxUnder + n] = 1'b1;
      fd_mask[FdRxStall + n] = 1'b1;
    end
    fdebug_d = (fdebug_q & ~(wr_fdebug ? (bus.wr_data & fd_mask) : 32'h0)) | fd_ev;
    irq_d    = (irq_q & ~irq_clr & ~(wr_irq ? bus.wr_data[7:0] : 8'h0)) | irq_set;
    intr     = {irq_q[3:0], 4'(tx_nfull), 4'(rx_nempty)};
  end

  always_comb begin
    rd_mux = '0;
    case (raddr)
      AddrCtrl:   rd_mux = 32'(enable_q);
      AddrFstat:  rd_mux = fstat;
      AddrFdebug: rd_mux = fdebug_q;
      AddrFlevel: rd_mux = flevel;
      AddrIrq:    rd_mux = 32'(irq_q);
      AddrIntr:   rd_mux = 32'(intr);
      default:    ;
    endcase
    for (int unsigned n = 0; n < NUM_SM; n++) begin
      if (raddr == sm_reg_addr(n, OffClkdiv))    rd_mux = clkdiv_q[n];
      if (raddr == sm_reg_addr(n, OffExecctrl))  rd_mux = execctrl_q[n];
      if (raddr == sm_reg_addr(n, OffShiftctrl)) rd_mux = shiftctrl_q[n];
      if (raddr == sm_reg_addr(n, OffAddr))      rd_mux = 32'(sm_pc[5*n +: 5]);
      if (raddr == sm_reg_addr(n, OffInstr))     rd_mux = 32'(instr_q[n]);
      if (raddr == sm_reg_addr(n, OffPinctrl))   rd_mux = pinctrl_q[n];
    end
    for (int unsigned k = 0; k < IRQ_LINES; k++) begin
      if (raddr == irq_reg_addr(k, OffInte)) rd_mux = 32'(inte[k]);
      if (raddr == irq_reg_addr(k, OffIntf)) rd_mux = 32'(intf[k]);
      if (raddr == irq_reg_addr(k, OffInts)) rd_mux = 32'(ints[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q         <= '0;
      sm_restart_q     <= '0;
      clkdiv_restart_q <= '0;
      instr_wr_q       <= '0;
      fdebug_q         <= '0;
      irq_q            <= '0;
      rd_data_q        <= '0;
      rd_valid_q       <= 1'b0;
      for (int unsigned n = 0; n < NUM_SM; n++) begin
        clkdiv_q[n]    <= RstClkdiv;
        execctrl_q[n]  <= RstExecctrl;
        shiftctrl_q[n] <= RstShiftctrl;
        pinctrl_q[n]   <= RstPinctrl;
        instr_q[n]     <= '0;
      end
    end else begin
      if (wr_ctrl) enable_q <= bus.wr_data[NUM_SM-1:0];
      sm_restart_q     <= wr_ctrl ? bus.wr_data[4 +: NUM_SM] : '0;
      clkdiv_restart_q <= wr_ctrl ? bus.wr_data[8 +: NUM_SM] : '0;
      instr_wr_q       <= wr_instr;
      fdebug_q         <= fdebug_d;
      irq_q            <= irq_d;
      rd_valid_q       <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux;
      for (int unsigned n = 0; n < NUM_SM; n++) begin
        if (wr_clkdiv[n])    clkdiv_q[n]    <= bus.wr_data;
        if (wr_execctrl[n])  execctrl_q[n]  <= bus.wr_data;
        if (wr_shiftctrl[n]) shiftctrl_q[n] <= bus.wr_data;
        if (wr_pinctrl[n])   pinctrl_q[n]   <= bus.wr_data;
        if (wr_instr[n])     instr_q[n]     <= bus.wr_data[15:0];
      end
    end
  end

  for (genvar k = 0; k < IRQ_LINES; k++) begin : g_irq
    pio_irq_agg u_agg (
      .clk     (clk),
      .rst_n   (rst_n),
      .intr    (intr),
      .inte_we (wr_inte[k]),
      .intf_we (wr_intf[k]),
      .wr_data (bus.wr_data[IntrW-1:0]),
      .inte    (inte[k]),
      .intf    (intf[k]),
      .ints    (ints[k]),
      .irq     (irq_out[k])
    );
  end

  for (genvar n = 0; n < NUM_SM; n++) begin : g_out
    assign clkdiv[32*n +: 32]     = clkdiv_q[n];
    assign execctrl[32*n +: 32]   = execctrl_q[n];
    assign shiftctrl[32*n +: 32]  = shiftctrl_q[n];
    assign pinctrl[32*n +: 32]    = pinctrl_q[n];
    assign instr_data[16*n +: 16] = instr_q[n];
  end

  assign sm_enable      = enable_q;
  assign sm_restart     = sm_restart_q;
  assign clkdiv_restart = clkdiv_restart_q;
  assign instr_wr       = instr_wr_q;
  assign irq_flags      = irq_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule
